lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, `ADDR_WIDTH (32), byte-address width.
- DATA_WIDTH, `DATA_WIDTH (32), data word width.

REQ-002 Clocking and reset SHALL be exactly as decided: one clock; reset is synchronous and active-high.

REQ-003 Ports, one per line: name, direction, width, meaning.
- i_sys_clk, in, 1, system clock.
- i_sys_rst, in, 1, synchronous active-high reset.
- i_lsu_req_valid, in, 1, request present.
- o_lsu_req_ready, out, 1, block can accept a request.
- i_lsu_req_wr, in, 1, 1 = store, 0 = load.
- i_lsu_req_size, in, 2, 00 byte, 01 half, 10 word, 11 reserved.
- i_lsu_req_sign, in, 1, load sign-extends when set.
- i_lsu_req_addr, in, ADDR_WIDTH, byte address.
- i_lsu_req_data, in, DATA_WIDTH, store data, right-aligned.
- o_lsu_rsp_valid, out, 1, one-cycle response pulse.
- o_lsu_rsp_data, out, DATA_WIDTH, load result; 0 for stores and errors.
- o_lsu_rsp_err, out, 1, misaligned or reserved-size request.
- o_ram_rd_en, out, 1, RAM read enable; RAM read data is combinational.
- o_ram_rd_addr, out, ADDR_WIDTH, word-aligned read address.
- i_ram_rd_data, in, DATA_WIDTH, RAM read word.
- o_ram_wr_en, out, 1, RAM write enable; RAM commits at posedge.
- o_ram_wr_addr, out, ADDR_WIDTH, word-aligned write address.
- o_ram_wr_data, out, DATA_WIDTH, full word to write.

Function
REQ-004 The FSM SHALL have states IDLE, READ, WRITE, RESP; o_lsu_req_ready SHALL be 1 only in IDLE.

REQ-005 A request SHALL be accepted on a posedge with valid&&ready, latching wr, size, sign, addr and data.

REQ-006 An error SHALL be raised when size==11, when size==01 and addr[0]==1, or when size==10 and addr[1:0]!=0.
- Next state RESP with err=1 and data=0.
- No RAM enable SHALL be asserted.

REQ-007 Load: IDLE->READ->RESP.
- In READ: rd_en=1, rd_addr={addr[31:2],2'b00}.
- The extracted result SHALL be captured at the end of READ.
- rsp_valid SHALL be high in the 2nd cycle after acceptance.

REQ-008 Load extraction SHALL take the byte at lane addr[1:0] or the half at lane addr[1].
- The value SHALL be zero-extended, or sign-extended when sign=1.
- Word loads SHALL pass unmodified.

REQ-009 Word store: IDLE->WRITE->RESP, with wr_en=1 and wr_data=req_data for exactly one cycle; rsp_valid SHALL follow 2 cycles after acceptance.

REQ-010 Sub-word store (read-modify-write): IDLE->READ->WRITE->RESP.
- READ SHALL capture the old word.
- WRITE SHALL write the old word with only the addressed byte/half lane replaced by req_data[7:0]/[15:0].
- rsp_valid SHALL follow 3 cycles after acceptance.

REQ-011 RESP SHALL last exactly one cycle, then return to IDLE. There is no response back-pressure; the consumer SHALL sample the pulse.

REQ-012 Outside READ, rd_en and rd_addr SHALL be 0; outside WRITE, wr_en, wr_addr and wr_data SHALL be 0.

REQ-013 rsp_data and rsp_err SHALL be 0 whenever rsp_valid=0.

REQ-014 A request presented while not ready SHALL be ignored and not latched; the requester holds it.

Reset
REQ-015 While i_sys_rst=1, at any state: state<=IDLE, latched fields<=0.

REQ-016 During a reset cycle, o_ram_wr_en and o_ram_rd_en SHALL be forced to 0, so reset in WRITE writes nothing.

REQ-017 Output values after reset: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, all RAM outputs 0.

Structure
REQ-018 A shared package lsu_pkg SHALL hold the size encoding enum (SZ_B, SZ_H, SZ_W) and the FSM state enum.

REQ-019 A combinational sub-module lsu_align SHALL perform load extraction/extension and store lane merging; the FSM and registers SHALL stay in lsu.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> rsp_data=0xDEADBEEF; rsp_valid 2 cycles after each acceptance.
- Byte store 0xA5 @0x13 over 0x11223344 -> RAM word 0xA5223344, exactly 1 write, rsp 3 cycles after acceptance.
- Byte load @0x13 of 0xA5223344: sign=1 -> 0xFFFFFFA5; sign=0 -> 0x000000A5. Half load @0x12, sign=1 -> 0xFFFFA522.
- Half store @0x11 -> rsp_err=1, rsp_data=0, no rd_en/wr_en asserted, rsp 1 cycle after acceptance; size=11 behaves identically.
- Reset asserted during WRITE of a sub-word store -> wr_en=0 that cycle, RAM unchanged, ready=1 the next cycle.
- Back-to-back requests with valid held high -> each accepted only in IDLE, no request lost or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// request legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Reserved size, odd half address or non-word-aligned word address.
  function automatic logic req_err(input logic [1:0] size, input logic [1:0] lo);
    logic e;
    case (size)
      SZ_B:    e = 1'b0;
      SZ_H:    e = lo[0];
      SZ_W:    e = (lo != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the LSU: extracts and extends a byte/half from a RAM word for
// loads, and merges store data into the old word for sub-word stores.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            i_size,
  input  logic                  i_sign,
  input  logic [1:0]            i_lane,
  input  logic [DATA_WIDTH-1:0] i_rd_word,
  input  logic [DATA_WIDTH-1:0] i_st_data,
  output logic [DATA_WIDTH-1:0] o_ld_data,
  output logic [DATA_WIDTH-1:0] o_st_word
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] ins;

  assign shamt   = {i_lane, 3'b000};
  assign shifted = i_rd_word >> shamt;

  always_comb begin
    o_ld_data = i_rd_word;
    mask      = '1;
    ins       = i_st_data;
    case (i_size)
      SZ_B: begin
        o_ld_data = {{(DATA_WIDTH-8){i_sign & shifted[7]}}, shifted[7:0]};
        mask      = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << shamt;
        ins       = {{(DATA_WIDTH-8){1'b0}}, i_st_data[7:0]} << shamt;
      end
      SZ_H: begin
        o_ld_data = {{(DATA_WIDTH-16){i_sign & shifted[15]}}, shifted[15:0]};
        mask      = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << shamt;
        ins       = {{(DATA_WIDTH-16){1'b0}}, i_st_data[15:0]} << shamt;
      end
      default: ;
    endcase
    o_st_word = (i_rd_word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding request, word RAM with combinational
// read, read-modify-write for sub-word stores.
//
// state | meaning
// IDLE  | ready for a request; illegal requests go straight to RESP
// READ  | RAM read; loads capture the extracted result, RMW stores the old word
// WRITE | single-cycle RAM write of the full (possibly merged) word
// RESP  | one-cycle response pulse, then back to IDLE
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_lsu_req_valid,
  output logic                  o_lsu_req_ready,
  input  logic                  i_lsu_req_wr,
  input  logic [1:0]            i_lsu_req_size,
  input  logic                  i_lsu_req_sign,
  input  logic [ADDR_WIDTH-1:0] i_lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] i_lsu_req_data,
  output logic                  o_lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_lsu_rsp_data,
  output logic                  o_lsu_rsp_err,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data
);

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] align_word;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] st_word;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign word_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  // WRITE merges into the old word held in word_q; READ extracts from live RAM data.
  assign align_word = (state_q == WRITE) ? word_q : i_ram_rd_data;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_size    (size_q),
    .i_sign    (sign_q),
    .i_lane    (addr_q[1:0]),
    .i_rd_word (align_word),
    .i_st_data (data_q),
    .o_ld_data (ld_data),
    .o_st_word (st_word)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wr_d            = wr_q;
    size_d          = size_q;
    sign_d          = sign_q;
    addr_d          = addr_q;
    data_d          = data_q;
    word_d          = word_q;
    err_d           = err_q;
    o_lsu_req_ready = 1'b0;
    o_lsu_rsp_valid = 1'b0;
    o_lsu_rsp_data  = '0;
    o_lsu_rsp_err   = 1'b0;
    o_ram_rd_en     = 1'b0;
    o_ram_rd_addr   = '0;
    o_ram_wr_en     = 1'b0;
    o_ram_wr_addr   = '0;
    o_ram_wr_data   = '0;

    case (state_q)
      IDLE: begin
        o_lsu_req_ready = 1'b1;
        if (i_lsu_req_valid) begin
          wr_d   = i_lsu_req_wr;
          size_d = i_lsu_req_size;
          sign_d = i_lsu_req_sign;
          addr_d = i_lsu_req_addr;
          data_d = i_lsu_req_data;
          err_d  = req_err(i_lsu_req_size, i_lsu_req_addr[1:0]);
          if (err_d) begin
            state_d = RESP;
          end else if (i_lsu_req_wr && (i_lsu_req_size == SZ_W)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        o_ram_rd_en   = 1'b1;
        o_ram_rd_addr = word_addr;
        word_d        = wr_q ? i_ram_rd_data : ld_data;
        state_d       = wr_q ? WRITE : RESP;
      end
      WRITE: begin
        o_ram_wr_en   = 1'b1;
        o_ram_wr_addr = word_addr;
        o_ram_wr_data = (size_q == SZ_W) ? data_q : st_word;
        state_d       = RESP;
      end
      RESP: begin
        o_lsu_rsp_valid = 1'b1;
        o_lsu_rsp_err   = err_q;
        o_lsu_rsp_data  = (err_q || wr_q) ? '0 : word_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset landing mid-access must not commit anything to the RAM.
    if (i_sys_rst) begin
      o_ram_rd_en = 1'b0;
      o_ram_wr_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a driver issues requests and queues expected
// responses; a negedge monitor pops and compares data, error and latency.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_data;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        rd_en, wr_en;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;

  logic [31:0] mem [0:63];
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    int          dly;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   nrsp  = 0;
  int   npush = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (rst),
    .i_lsu_req_valid (req_valid),
    .o_lsu_req_ready (req_ready),
    .i_lsu_req_wr    (req_wr),
    .i_lsu_req_size  (req_size),
    .i_lsu_req_sign  (req_sign),
    .i_lsu_req_addr  (req_addr),
    .i_lsu_req_data  (req_data),
    .o_lsu_rsp_valid (rsp_valid),
    .o_lsu_rsp_data  (rsp_data),
    .o_lsu_rsp_err   (rsp_err),
    .o_ram_rd_en     (rd_en),
    .o_ram_rd_addr   (rd_addr),
    .i_ram_rd_data   (rd_data),
    .o_ram_wr_en     (wr_en),
    .o_ram_wr_addr   (wr_addr),
    .o_ram_wr_data   (wr_data)
  );

  assign rd_data = mem[rd_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      mem[wr_addr[7:2]] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        nrsp++;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got data 0x%08h err %0b with nothing expected", rsp_data, rsp_err);
        end else begin
          e = sbq.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("rsp_latency", cyc - e.acc, e.dly);
        end
      end
      chk("quiet_outputs",
          {31'b0, (!rsp_valid && (rsp_data != 0 || rsp_err)) ||
                  (!rd_en && rd_addr != 0) ||
                  (!wr_en && (wr_addr != 0 || wr_data != 0))},
          32'd0);
    end
  end

  // dly: negedge-sampled cycles from the acceptance edge to the response cycle, minus one.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e,
                       input int dly, input bit push);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_size  = sz;
    req_sign  = sg;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: ready %0b required 1 for addr 0x%08h", req_ready, a);
    end else if (push) begin
      sbq.push_back('{exp_d, exp_e, cyc + 1, dly});
      npush++;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_size  = 2'b00;
    req_sign  = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp", {30'b0, rsp_valid, rsp_err} | rsp_data, 32'd0);
    chk("reset_ram", {30'b0, rd_en, wr_en} | rd_addr | wr_addr | wr_data, 32'd0);

    // word store then word load, valid held high across both
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1'b1);
    drain();
    chk("mem_word_store", mem[4], 32'hDEADBEEF);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1, 1'b1);
    drain();
    w0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456A5, 32'h0, 1'b0, 2, 1'b1);
    drain();
    chk("mem_byte_store", mem[4], 32'hA5223344);
    chk("rmw_single_write", wr_cnt - w0, 32'd1);

    // back-to-back sub-word loads; later fields change while the unit is busy
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 1, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000A5, 1'b0, 1, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFA522, 1'b0, 1, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00003344, 1'b0, 1, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h00000044, 1'b0, 1, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h00000022, 1'b0, 1, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h9999BEEF, 32'h0, 1'b0, 2, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hA522BEEF, 1'b0, 1, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 1, 1'b1);
    drain();

    // illegal requests: no RAM traffic, immediate error response
    w0 = wr_cnt;
    r0 = rd_cnt;
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h55AA, 32'h0, 1'b1, 0, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h1234, 32'h0, 1'b1, 0, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 0, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h0, 1'b1, 0, 1'b1);
    drain();
    chk("err_no_write", wr_cnt - w0, 32'd0);
    chk("err_no_read", rd_cnt - r0, 32'd0);
    chk("err_mem_intact", mem[4], 32'hA522BEEF);

    // reset landing in the WRITE cycle of a read-modify-write
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1, 1'b1);
    drain();
    w0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000077, 32'h0, 1'b0, 2, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_write_wr_en", {31'b0, wr_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_unchanged", mem[8], 32'hCAFEF00D);
    chk("rst_no_write", wr_cnt - w0, 32'd0);

    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1, 1'b1);
    drain();

    chk("rsp_count", nrsp, npush);
    chk("queue_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
